action_dispatcher: RTL and testbench
====================================

ACTION_DISPATCHER -- requirements
Module: action_dispatcher

Interface
REQ-001 Parameter COOLDOWN_CYC, default 4, sets the number of cycles a repulsor grant blocks further repulsor requests.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  action request present.
REQ-005 req_ready  out  1  dispatcher can accept a request.
REQ-006 req_op  in  2  0 REPULSOR, 1 WEB, 2 THRUSTER, 3 RECHARGE.
REQ-007 req_qty  in  3  repetition count, 0..7.
REQ-008 energy_lvl / tracer_lvl / fluid_lvl  in  8 / 6 / 4  current store contents.
REQ-009 energy_en, energy_load  out  1, 8  write strobe and new value for the energy store.
REQ-010 tracer_en, tracer_load  out  1, 6  write strobe and new value for the tracer store.
REQ-011 fluid_en, fluid_load  out  1, 4  write strobe and new value for the fluid store.
REQ-012 rsp_valid  out  1  response present; rsp_ready  in  1  consumer accepts response.
REQ-013 rsp_grant  out  1  action granted; rsp_code  out  3  0 OK, 1 NO_ENERGY, 2 NO_TRACER, 3 NO_FLUID, 4 COOLDOWN.

Function
REQ-014 Costs SHALL be: REPULSOR energy 16*qty; WEB tracer qty and fluid qty; THRUSTER energy 4*qty; RECHARGE adds 32*qty energy, saturating at 255.
REQ-015 States SHALL be IDLE, CHECK, COMMIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: req_valid && req_ready captures op and qty, next state CHECK.
REQ-017 CHECK: levels are sampled and registered; sufficiency is decided (level >= cost, unsigned, full width); next state COMMIT.
REQ-018 Deny priority SHALL be: COOLDOWN (repulsor with cooldown counter nonzero), then NO_ENERGY, then NO_TRACER, then NO_FLUID.
REQ-019 COMMIT: on grant, assert the enables of every affected store for exactly one cycle, with load = sampled level minus cost (or saturated sum for RECHARGE); on deny, no enable; next state RESP.
REQ-020 RESP: rsp_valid=1 with stable rsp_grant/rsp_code until rsp_valid && rsp_ready, then IDLE.
REQ-021 Latency: request accepted on edge T gives rsp_valid high from edge T+3; earliest next acceptance on edge T+4.
REQ-022 Exact-equality level == cost SHALL grant and load 0.
REQ-023 qty 0 SHALL grant with rsp_code OK and assert no enables.
REQ-024 WEB is all-or-nothing: if either tracer or fluid is insufficient, neither store is written.
REQ-025 A granted REPULSOR loads the cooldown counter with COOLDOWN_CYC in COMMIT; the counter decrements every cycle to 0 and never wraps.
REQ-026 Store-enable outputs SHALL be 0 in every state except COMMIT.

Reset
REQ-027 reset SHALL force state IDLE, cooldown 0, all enables 0, all load values 0, rsp_valid 0, rsp_grant 0, rsp_code 0; req_ready SHALL be 0 during the reset cycle and 1 on the first cycle after.
REQ-028 reset asserted in any state SHALL abandon the pending request with no store write and no response.

Structure
REQ-029 Op encodings, response codes, cost constants (16, 4, 32) and the 255 saturation limit SHALL live in a shared package.
REQ-030 Cost and sufficiency evaluation SHALL be one combinational sub-module named action_cost; the FSM and cooldown counter stay in action_dispatcher.

Verification
REQ-031 Bench SHALL cover the scenarios REQ-032 to REQ-036.
REQ-032 energy_lvl=255, REPULSOR qty 3 -> energy_en one cycle, energy_load=207, rsp OK, rsp_valid at T+3.
REQ-033 REPULSOR granted, then REPULSOR re-requested immediately -> rsp_code COOLDOWN, no enable.
REQ-034 tracer_lvl=5, fluid_lvl=2, WEB qty 3 -> rsp_code NO_FLUID, neither store written.
REQ-035 energy_lvl=200, RECHARGE qty 2 -> energy_load=255 (saturated), rsp OK.
REQ-036 reset asserted during CHECK -> no enable, no rsp_valid, req_ready=1 on the following cycle; next request served normally.

Source files
------------

// File: rtl/action_dispatcher_pkg.sv
// action_dispatcher_pkg: op/response encodings, FSM states and cost constants
// shared by the dispatcher and its cost evaluator.
package action_dispatcher_pkg;
   typedef enum logic [1:0] {OP_REPULSOR, OP_WEB, OP_THRUSTER, OP_RECHARGE} op_t;
   typedef enum logic [2:0] {RC_OK, RC_NO_ENERGY, RC_NO_TRACER, RC_NO_FLUID, RC_COOLDOWN} rsp_code_t;
   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_COMMIT, ST_RESP} state_t;
   localparam int REPULSOR_COST = 16;
   localparam int THRUSTER_COST = 4;
   localparam int RECHARGE_GAIN = 32;
   localparam int ENERGY_MAX    = 255;
endpackage

// File: rtl/action_cost.sv
// action_cost: combinational cost, sufficiency and new store values for one action.
module action_cost
   import action_dispatcher_pkg::*;
(
   input  op_t        i_op,
   input  logic [2:0] i_qty,
   input  logic [7:0] i_energy,
   input  logic [5:0] i_tracer,
   input  logic [3:0] i_fluid,
   input  logic       i_cooldown,
   output logic       o_grant,
   output rsp_code_t  o_code,
   output logic       o_energy_en,
   output logic [7:0] o_energy_load,
   output logic       o_tracer_en,
   output logic [5:0] o_tracer_load,
   output logic       o_fluid_en,
   output logic [3:0] o_fluid_load
);
   logic [8:0] w_qty;
   logic [8:0] w_ecost;
   logic [8:0] w_sum;
   logic       w_web;
   logic       w_act;
   always_comb begin
      w_qty         = {6'd0, i_qty};
      w_web         = i_op == OP_WEB;
      w_ecost       = i_op == OP_REPULSOR ? 9'(REPULSOR_COST) * w_qty
                    : i_op == OP_THRUSTER ? 9'(THRUSTER_COST) * w_qty : 9'd0;
      // 9-bit sum so the recharge overflow is visible before saturating
      w_sum         = {1'b0, i_energy} + 9'(RECHARGE_GAIN) * w_qty;
      o_code        = (i_op == OP_REPULSOR && i_cooldown) ? RC_COOLDOWN
                    : {1'b0, i_energy} < w_ecost ? RC_NO_ENERGY
                    : (w_web && i_tracer < {3'd0, i_qty}) ? RC_NO_TRACER
                    : (w_web && i_fluid < {1'b0, i_qty}) ? RC_NO_FLUID : RC_OK;
      o_grant       = o_code == RC_OK;
      w_act         = o_grant && i_qty != 3'd0;
      o_energy_en   = w_act && !w_web;
      o_tracer_en   = w_act && w_web;
      o_fluid_en    = w_act && w_web;
      o_energy_load = i_op == OP_RECHARGE ? (w_sum > 9'(ENERGY_MAX) ? 8'(ENERGY_MAX) : w_sum[7:0])
                    : i_energy - w_ecost[7:0];
      o_tracer_load = i_tracer - {3'd0, i_qty};
      o_fluid_load  = i_fluid - {1'b0, i_qty};
   end
endmodule

// File: rtl/action_dispatcher.sv
// action_dispatcher: request FSM that checks resource stores, commits one-cycle
// store writes on grant and returns a grant/code response; owns the repulsor cooldown.
module action_dispatcher
   import action_dispatcher_pkg::*;
#(
   parameter int COOLDOWN_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [2:0] req_qty,
   input  logic [7:0] energy_lvl,
   input  logic [5:0] tracer_lvl,
   input  logic [3:0] fluid_lvl,
   output logic       energy_en,
   output logic [7:0] energy_load,
   output logic       tracer_en,
   output logic [5:0] tracer_load,
   output logic       fluid_en,
   output logic [3:0] fluid_load,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_grant,
   output logic [2:0] rsp_code
);
   localparam int CW = $clog2(COOLDOWN_CYC + 2);
   state_t     r_state;
   state_t     w_next;
   op_t        r_op;
   logic [2:0] r_qty;
   logic [CW-1:0] r_cool;
   logic       r_grant;
   rsp_code_t  r_code;
   logic       r_een;
   logic       r_ten;
   logic       r_fen;
   logic [7:0] r_eload;
   logic [5:0] r_tload;
   logic [3:0] r_fload;
   logic       w_grant;
   rsp_code_t  w_code;
   logic       w_een;
   logic       w_ten;
   logic       w_fen;
   logic [7:0] w_eload;
   logic [5:0] w_tload;
   logic [3:0] w_fload;
   logic       w_commit;

   action_cost u_cost (
      .i_op          (r_op),
      .i_qty         (r_qty),
      .i_energy      (energy_lvl),
      .i_tracer      (tracer_lvl),
      .i_fluid       (fluid_lvl),
      .i_cooldown    (r_cool != '0),
      .o_grant       (w_grant),
      .o_code        (w_code),
      .o_energy_en   (w_een),
      .o_energy_load (w_eload),
      .o_tracer_en   (w_ten),
      .o_tracer_load (w_tload),
      .o_fluid_en    (w_fen),
      .o_fluid_load  (w_fload)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= OP_REPULSOR;
         r_qty   <= '0;
         r_cool  <= '0;
         r_grant <= 1'b0;
         r_code  <= RC_OK;
         r_een   <= 1'b0;
         r_ten   <= 1'b0;
         r_fen   <= 1'b0;
         r_eload <= '0;
         r_tload <= '0;
         r_fload <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && req_valid) begin
            r_op  <= op_t'(req_op);
            r_qty <= req_qty;
         end
         // levels are sampled here; COMMIT replays the registered decision
         if (r_state == ST_CHECK) begin
            r_grant <= w_grant;
            r_code  <= w_code;
            r_een   <= w_een;
            r_ten   <= w_ten;
            r_fen   <= w_fen;
            r_eload <= w_eload;
            r_tload <= w_tload;
            r_fload <= w_fload;
         end
         r_cool <= (r_state == ST_COMMIT && r_grant && r_op == OP_REPULSOR) ? CW'(COOLDOWN_CYC)
                 : r_cool - CW'(r_cool != '0);
      end
   end

   always_comb begin
      w_next      = r_state == ST_IDLE ? (req_valid ? ST_CHECK : ST_IDLE)
                  : r_state == ST_CHECK ? ST_COMMIT
                  : r_state == ST_COMMIT ? ST_RESP
                  : (rsp_ready ? ST_IDLE : ST_RESP);
      req_ready   = r_state == ST_IDLE && !reset;
      w_commit    = r_state == ST_COMMIT && !reset;
      energy_en   = w_commit && r_een;
      tracer_en   = w_commit && r_ten;
      fluid_en    = w_commit && r_fen;
      energy_load = energy_en ? r_eload : 8'd0;
      tracer_load = tracer_en ? r_tload : 6'd0;
      fluid_load  = fluid_en ? r_fload : 4'd0;
      rsp_valid   = r_state == ST_RESP && !reset;
      rsp_grant   = rsp_valid && r_grant;
      rsp_code    = rsp_valid ? r_code : RC_OK;
   end
endmodule

// File: tb/tb_action_dispatcher.sv
// tb_action_dispatcher: directed requests push expected responses into a queue;
// a monitor pops and compares on each response handshake.
module tb_action_dispatcher;
   typedef struct {
      logic       grant;
      logic [2:0] code;
      logic       een;
      logic [7:0] el;
      logic       ten;
      logic [5:0] tl;
      logic       fen;
      logic [3:0] fl;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = '0;
   logic [2:0] req_qty = '0;
   logic [7:0] energy_lvl = '0;
   logic [5:0] tracer_lvl = '0;
   logic [3:0] fluid_lvl = '0;
   logic       energy_en;
   logic [7:0] energy_load;
   logic       tracer_en;
   logic [5:0] tracer_load;
   logic       fluid_en;
   logic [3:0] fluid_load;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic       rsp_grant;
   logic [2:0] rsp_code;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q[$];
   exp_t m_e;
   int   e_cnt = 0;
   int   t_cnt = 0;
   int   f_cnt = 0;
   logic [7:0] e_val = '0;
   logic [5:0] t_val = '0;
   logic [3:0] f_val = '0;
   logic seen = 1'b0;
   int   first = 0;

   // op, qty, energy, tracer, fluid, grant, code, een, eload, ten, tload, fen, fload
   int vec [0:17][0:12] = '{
      '{0, 3, 255,  0,  0, 1, 0, 1, 207, 0,  0, 0, 0},
      '{0, 1, 255,  0,  0, 0, 4, 0,   0, 0,  0, 0, 0},
      '{0, 3,  47,  0,  0, 0, 1, 0,   0, 0,  0, 0, 0},
      '{0, 3,  48,  0,  0, 1, 0, 1,   0, 0,  0, 0, 0},
      '{0, 7,   0,  0,  0, 0, 4, 0,   0, 0,  0, 0, 0},
      '{1, 3,   0,  5,  2, 0, 3, 0,   0, 0,  0, 0, 0},
      '{1, 3,   0,  2,  9, 0, 2, 0,   0, 0,  0, 0, 0},
      '{1, 3,   0,  5,  3, 1, 0, 0,   0, 1,  2, 1, 0},
      '{3, 2, 200,  0,  0, 1, 0, 1, 255, 0,  0, 0, 0},
      '{3, 1, 100,  0,  0, 1, 0, 1, 132, 0,  0, 0, 0},
      '{2, 7,  30,  0,  0, 1, 0, 1,   2, 0,  0, 0, 0},
      '{2, 7,  27,  0,  0, 0, 1, 0,   0, 0,  0, 0, 0},
      '{2, 0,   0,  0,  0, 1, 0, 0,   0, 0,  0, 0, 0},
      '{1, 0,   0,  0,  0, 1, 0, 0,   0, 0,  0, 0, 0},
      '{1, 7,   0, 63, 15, 1, 0, 0,   0, 1, 56, 1, 8},
      '{3, 7, 255,  0,  0, 1, 0, 1, 255, 0,  0, 0, 0},
      '{2, 2,   8,  0,  0, 1, 0, 1,   0, 0,  0, 0, 0},
      '{0, 1,  16,  0,  0, 1, 0, 1,   0, 0,  0, 0, 0}
   };

   action_dispatcher #(.COOLDOWN_CYC(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_qty     (req_qty),
      .energy_lvl  (energy_lvl),
      .tracer_lvl  (tracer_lvl),
      .fluid_lvl   (fluid_lvl),
      .energy_en   (energy_en),
      .energy_load (energy_load),
      .tracer_en   (tracer_en),
      .tracer_load (tracer_load),
      .fluid_en    (fluid_en),
      .fluid_load  (fluid_load),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_grant   (rsp_grant),
      .rsp_code    (rsp_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input int i);
      int   n = 0;
      exp_t x;
      @(negedge clk);
      req_op     = 2'(vec[i][0]);
      req_qty    = 3'(vec[i][1]);
      energy_lvl = 8'(vec[i][2]);
      tracer_lvl = 6'(vec[i][3]);
      fluid_lvl  = 4'(vec[i][4]);
      req_valid  = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      x.grant = 1'(vec[i][5]);
      x.code  = 3'(vec[i][6]);
      x.een   = 1'(vec[i][7]);
      x.el    = 8'(vec[i][8]);
      x.ten   = 1'(vec[i][9]);
      x.tl    = 6'(vec[i][10]);
      x.fen   = 1'(vec[i][11]);
      x.fl    = 4'(vec[i][12]);
      x.acc   = cyc + 1;
      q.push_back(x);
      @(negedge clk);
      req_valid = 1'b0;
      // hold levels through the CHECK sampling edge
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", q.size(), 0);
   endtask

   always begin
      @(negedge clk);
      #2;
      if (energy_en) begin
         e_cnt++;
         e_val = energy_load;
      end
      if (tracer_en) begin
         t_cnt++;
         t_val = tracer_load;
      end
      if (fluid_en) begin
         f_cnt++;
         f_val = fluid_load;
      end
      if (rsp_valid && !seen) begin
         seen  = 1'b1;
         first = cyc + 1;
      end
      if (rsp_valid && rsp_ready) begin
         seen = 1'b0;
         if (q.size() == 0) chk("unexpected_rsp", 1, 0);
         else begin
            m_e = q.pop_front();
            chk("rsp_grant", rsp_grant, m_e.grant);
            chk("rsp_code", rsp_code, m_e.code);
            chk("rsp_latency", first - m_e.acc, 3);
            chk("energy_en_cycles", e_cnt, m_e.een);
            chk("tracer_en_cycles", t_cnt, m_e.ten);
            chk("fluid_en_cycles", f_cnt, m_e.fen);
            if (m_e.een) chk("energy_load", e_val, m_e.el);
            if (m_e.ten) chk("tracer_load", t_val, m_e.tl);
            if (m_e.fen) chk("fluid_load", f_val, m_e.fl);
         end
         e_cnt = 0;
         t_cnt = 0;
         f_cnt = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_grant", rsp_grant, 0);
      chk("reset_rsp_code", rsp_code, 0);
      chk("reset_energy_en", energy_en, 0);
      chk("reset_energy_load", energy_load, 0);
      chk("reset_tracer_en", tracer_en, 0);
      chk("reset_fluid_en", fluid_en, 0);
      reset = 1'b0;
      #1;
      chk("post_reset_req_ready", req_ready, 1);
      for (int i = 0; i < 16; i++) begin
         issue(i);
         if (i == 7) begin
            rsp_ready = 1'b0;
            repeat (6) @(negedge clk);
            rsp_ready = 1'b1;
         end
      end
      drain();
      // abandon a would-be repulsor grant by resetting while it is in CHECK
      @(negedge clk);
      req_op     = 2'd0;
      req_qty    = 3'd1;
      energy_lvl = 8'd255;
      req_valid  = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      chk("abort_req_ready_in_reset", req_ready, 0);
      chk("abort_rsp_valid_in_reset", rsp_valid, 0);
      chk("abort_energy_en_in_reset", energy_en, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_req_ready_after", req_ready, 1);
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("abort_no_rsp", rsp_valid, 0);
         chk("abort_no_write", energy_en, 0);
      end
      issue(16);
      issue(17);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
